ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Pipeline interlock controller for the 16-bit execute stage. Tracks register producers in EX/MEM/WB.
//  Drives operand-forwarding selects for the ALU A/B inputs, load-use and RAW stalls, and flushes on a
//  resolved branch or jump. Sits beside decode/execute and feeds the IF/ID and ID/EX pipeline-register enables.
// PARAMETERS
//  REG_W        3   register-address width (8 GPRs)
//  STALL_CNT_W  16  width of the saturating stall-cycle counter
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset; asynchronous, active-high
//  id_valid       in   1        ID holds a real instruction
//  id_rs,id_rt    in   REG_W    ID source registers
//  id_rs_use      in   1        ID reads rs
//  id_rt_use      in   1        ID reads rt
//  id_rd          in   REG_W    ID destination register
//  id_wr          in   1        ID writes a register
//  id_ld          in   1        ID is a load
//  ex_take_br     in   1        EX branch taken or jump (PC select = target)
//  mem_busy       in   1        data memory not ready; freeze whole pipe
//  stall_if       out  1        hold PC and IF/ID
//  stall_id       out  1        hold ID; inject bubble into ID/EX
//  flush_ifid     out  1        kill IF/ID contents
//  flush_idex     out  1        kill ID/EX contents
//  fwd_a,fwd_b    out  2        EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 unused
//  stall_cycles   out  STALL_CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Tracker: slots EX, MEM, WB, each {valid, rd, wr, ld}; EX slot also holds rs/rt/rs_use/rt_use.
//    Advance on every clk edge unless mem_busy=1, which holds all slots.
//  - Advance: EX<=ID fields (valid=0 when bubble or flush), MEM<=EX, WB<=MEM.
//  - Match(s, r): s.valid & s.wr & s.rd==r. Register 0 is a normal GPR and is not special.
//  - Priority, all combinational on the current cycle:
//    mem_busy > ex_take_br > hazard > run.
//  - mem_busy=1: stall_if=stall_id=1, flushes=0, stall_cycles not incremented.
//  - ex_take_br=1 and EX.valid: flush_ifid=flush_idex=1, stall_*=0.
//    The next EX slot is invalid, giving a 2-cycle penalty. Any pending hazard stall is discarded.
//  - Hazard (id_valid, source in use) -> stall_if=stall_id=1 and a bubble into EX; stall_cycles += 1.
//    The counter saturates at all ones.
//  - fwd_a (EX.rs, EX.rs_use): 01 if Match(MEM), else 10 if Match(WB), else 00. fwd_b is the same on rt.
//    MEM wins over WB. MEM.ld never sources 01; that case is prevented by the load-use stall.
//  - FSM (perf/debug state only; outputs stay combinational as above):
//    RUN -> HAZ when a hazard stall is issued; HAZ -> RUN when there is no hazard.
//    RUN/HAZ -> FLUSH on ex_take_br; FLUSH -> RUN after 1 cycle.
//    Any state -> MEMW while mem_busy; MEMW returns to the previous state when mem_busy drops.
//  - Reset: all slots invalid, FSM=RUN, stall_cycles=0, fwd_*=00, all stall/flush outputs 0.
//    Reset mid-stall drops the stall at once (async).
// CONFIGURATION
//  - FORWARD_EN defined: the hazard condition is load-use only.
//    ID source matches EX with EX.ld=1, giving exactly 1 stall cycle.
//  - FORWARD_EN undefined: fwd_a=fwd_b=00 always.
//    The hazard is any ID source matching EX, MEM or WB (regfile has no write-through).
//    This gives up to 3 stall cycles.
// STRUCTURE
//  - Shared package/include: FWD_RF=2'b00, FWD_EXM=2'b01, FWD_MWB=2'b10.
//    Also FSM state encodings RUN/HAZ/FLUSH/MEMW and the slot-field struct widths.
//  - One sub-module: ex_hazard_slot, the per-stage {valid,rd,wr,ld} register with hold/clear.
//    Instantiated 3x.
// TESTING
//  1. FORWARD_EN: ADD r1 then ADD r2,r1,r3 -> no stall; fwd_a=01 when 2nd in EX.
//     With one NOP between -> fwd_a=10.
//  2. FORWARD_EN: LD r4 then ADD r5,r4,r4 -> 1 cycle stall_if=stall_id=1, then fwd_a=fwd_b=01? No: MEM.ld
//     is in WB by then -> fwd_a=fwd_b=10; stall_cycles=1.
//  3. No FORWARD_EN: ADD r1 then SUB r2,r1,r1 -> 3 stall cycles; fwd always 00; stall_cycles=3.
//  4. Taken BEQZ in EX while ID has a load-use hazard -> flush_ifid=flush_idex=1, stall=0.
//     Next cycle EX.valid=0, FSM FLUSH->RUN.
//  5. mem_busy held 4 cycles during a pending RAW -> stalls held, slots frozen, stall_cycles unchanged.
//     The hazard resolves normally after release.
//  6. rst pulsed mid-hazard (async, between edges) -> all outputs 0 immediately; stall_cycles=0.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl_pkg
//   Shared definitions for the execute-stage hazard controller:
//     - operand-forwarding select encodings (FWD_RF / FWD_EXM / FWD_MWB)
//     - observer FSM state encodings (RUN / HAZ / FLUSH / MEMW)
//     - per-slot flag struct {valid, wr, ld} and slot indices
//     - fwd_select helper (MEM result has priority over WB result)
// ----------------------------------------------------------------------------
package ex_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_EXM = 2'b01;  // EX/MEM result
    localparam logic [1:0] FWD_MWB = 2'b10;  // MEM/WB result

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MEMW  = 2'd3
    } hz_state_e;

    // Flag part of a tracker slot; rd is carried alongside with width REG_W.
    typedef struct packed {
        logic valid;
        logic wr;
        logic ld;
    } slot_flags_t;

    localparam int SLOT_FLAGS_W = $bits(slot_flags_t);

    localparam int NUM_SLOTS = 3;
    localparam int SLOT_EX   = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;

    // The younger producer (MEM) holds the most recent value, so it wins.
    function automatic logic [1:0] fwd_select(input logic hit_mem, input logic hit_wb);
        if (hit_mem)
            return FWD_EXM;
        else if (hit_wb)
            return FWD_MWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_hazard_slot.sv
// ----------------------------------------------------------------------------
// ex_hazard_slot
//   One pipeline-stage entry of the producer tracker: {valid, wr, ld} flags
//   plus destination register. Loads every clock unless held; a clear loads
//   an empty (invalid) entry instead of the incoming one.
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   i_hold     keep current contents
//   i_clr      load an invalid entry (bubble / flush)
//   i_flags    incoming flags;  i_rd incoming destination register
//   o_flags    stored flags;    o_rd stored destination register
// ----------------------------------------------------------------------------
module ex_hazard_slot
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_clr,
    input  slot_flags_t       i_flags,
    input  logic [REG_W-1:0]  i_rd,
    output slot_flags_t       o_flags,
    output logic [REG_W-1:0]  o_rd
);

    slot_flags_t      r_flags;
    logic [REG_W-1:0] r_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
            r_rd    <= '0;
        end else if (!i_hold) begin
            r_flags <= i_clr ? slot_flags_t'('0) : i_flags;
            r_rd    <= i_rd;
        end
    end

    assign o_flags = r_flags;
    assign o_rd    = r_rd;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//   Pipeline interlock controller for the 16-bit execute stage. Tracks the
//   register producers in EX/MEM/WB, drives ALU operand-forwarding selects,
//   load-use / RAW stalls and branch/jump flushes.
//
// Build option (macro FORWARD_EN):
//   defined   : forwarding active, only load-use stalls (1 cycle).
//   undefined : fwd_a/fwd_b fixed at 00, any RAW against EX/MEM/WB stalls.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_id_valid               ID holds a real instruction
//   i_id_rs, i_id_rt         ID source registers; i_id_rs_use/i_id_rt_use read flags
//   i_id_rd, i_id_wr, i_id_ld ID destination, writes-register, is-load
//   i_ex_take_br             EX branch taken / jump
//   i_mem_busy               data memory not ready, freeze the pipe
//   o_stall_if, o_stall_id   hold PC+IF/ID ; hold ID and bubble ID/EX
//   o_flush_ifid, o_flush_idex kill IF/ID ; kill ID/EX
//   o_fwd_a, o_fwd_b         EX operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   o_stall_cycles           saturating count of hazard-stall cycles
//   o_fsm_state              observer FSM state (perf/debug only)
// ----------------------------------------------------------------------------
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_id_valid,
    input  logic [REG_W-1:0]       i_id_rs,
    input  logic [REG_W-1:0]       i_id_rt,
    input  logic                   i_id_rs_use,
    input  logic                   i_id_rt_use,
    input  logic [REG_W-1:0]       i_id_rd,
    input  logic                   i_id_wr,
    input  logic                   i_id_ld,
    input  logic                   i_ex_take_br,
    input  logic                   i_mem_busy,
    output logic                   o_stall_if,
    output logic                   o_stall_id,
    output logic                   o_flush_ifid,
    output logic                   o_flush_idex,
    output logic [1:0]             o_fwd_a,
    output logic [1:0]             o_fwd_b,
    output logic [STALL_CNT_W-1:0] o_stall_cycles,
    output hz_state_e              o_fsm_state
);

    // ------------------------------------------------------------------
    // Producer tracker: slot 0 = EX, 1 = MEM, 2 = WB
    // ------------------------------------------------------------------
    slot_flags_t           w_slot_d  [NUM_SLOTS];
    slot_flags_t           w_slot_q  [NUM_SLOTS];
    logic [REG_W-1:0]      w_rd_d    [NUM_SLOTS];
    logic [REG_W-1:0]      w_rd_q    [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  w_id_hit;
    logic                  w_bubble;

    function automatic logic slot_match(input slot_flags_t f, input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] r);
        return f.valid & f.wr & (rd == r);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi == 0) begin : g_from_id
                assign w_slot_d[gi] = '{valid: i_id_valid, wr: i_id_wr, ld: i_id_ld};
                assign w_rd_d[gi]   = i_id_rd;
            end else begin : g_from_prev
                assign w_slot_d[gi] = w_slot_q[gi-1];
                assign w_rd_d[gi]   = w_rd_q[gi-1];
            end

            // Only the EX entry takes bubbles; older stages just shift.
            ex_hazard_slot #(.REG_W(REG_W)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_hold  (i_mem_busy),
                .i_clr   ((gi == 0) ? w_bubble : 1'b0),
                .i_flags (w_slot_d[gi]),
                .i_rd    (w_rd_d[gi]),
                .o_flags (w_slot_q[gi]),
                .o_rd    (w_rd_q[gi])
            );

            // Does the instruction in ID read a register this slot will write?
            assign w_id_hit[gi] = i_id_valid &
                ((i_id_rs_use & slot_match(w_slot_q[gi], w_rd_q[gi], i_id_rs)) |
                 (i_id_rt_use & slot_match(w_slot_q[gi], w_rd_q[gi], i_id_rt)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detection and forwarding
    // ------------------------------------------------------------------
    logic w_hazard;

`ifdef FORWARD_EN
    // EX entry also remembers its sources so forwarding can be resolved.
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic             r_ex_rs_use;
    logic             r_ex_rt_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_rs_use <= 1'b0;
            r_ex_rt_use <= 1'b0;
        end else if (!i_mem_busy) begin
            r_ex_rs     <= i_id_rs;
            r_ex_rt     <= i_id_rt;
            r_ex_rs_use <= i_id_rs_use;
            r_ex_rt_use <= i_id_rt_use;
        end
    end

    // A load's data exists only after MEM, so a dependent in ID waits one cycle.
    assign w_hazard = w_id_hit[SLOT_EX] & w_slot_q[SLOT_EX].ld;

    assign o_fwd_a = (w_slot_q[SLOT_EX].valid & r_ex_rs_use)
        ? fwd_select(slot_match(w_slot_q[SLOT_MEM], w_rd_q[SLOT_MEM], r_ex_rs),
                     slot_match(w_slot_q[SLOT_WB],  w_rd_q[SLOT_WB],  r_ex_rs))
        : FWD_RF;
    assign o_fwd_b = (w_slot_q[SLOT_EX].valid & r_ex_rt_use)
        ? fwd_select(slot_match(w_slot_q[SLOT_MEM], w_rd_q[SLOT_MEM], r_ex_rt),
                     slot_match(w_slot_q[SLOT_WB],  w_rd_q[SLOT_WB],  r_ex_rt))
        : FWD_RF;

    logic w_unused_ld;
    assign w_unused_ld = w_slot_q[SLOT_MEM].ld ^ w_slot_q[SLOT_WB].ld;
`else
    // No bypass and no regfile write-through: wait until the producer retires.
    assign w_hazard = |w_id_hit;
    assign o_fwd_a  = FWD_RF;
    assign o_fwd_b  = FWD_RF;

    logic w_unused_ld;
    assign w_unused_ld = w_slot_q[SLOT_EX].ld ^ w_slot_q[SLOT_MEM].ld ^ w_slot_q[SLOT_WB].ld;
`endif

    // ------------------------------------------------------------------
    // Stall / flush priority: mem_busy > branch > hazard > run
    // ------------------------------------------------------------------
    logic w_flush_take;
    logic w_haz_stall;

    assign w_flush_take = i_ex_take_br & w_slot_q[SLOT_EX].valid;

    always_comb begin
        o_stall_if   = 1'b0;
        o_stall_id   = 1'b0;
        o_flush_ifid = 1'b0;
        o_flush_idex = 1'b0;
        w_haz_stall  = 1'b0;
        if (i_mem_busy) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
        end else if (w_flush_take) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end else if (w_hazard) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            w_haz_stall = 1'b1;
        end
    end

    // While mem_busy the slots hold, so the bubble value is irrelevant there.
    assign w_bubble = w_flush_take | w_haz_stall;

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_haz_stall && (r_stall_cycles != {STALL_CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign o_stall_cycles = r_stall_cycles;

    // ------------------------------------------------------------------
    // Observer FSM
    // ------------------------------------------------------------------
    hz_state_e r_state;
    hz_state_e r_prev_state;
    hz_state_e w_state_next;
    hz_state_e w_prev_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_prev_state <= ST_RUN;
        end else begin
            r_state      <= w_state_next;
            r_prev_state <= w_prev_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_prev_next  = r_prev_state;
        if (i_mem_busy) begin
            w_state_next = ST_MEMW;
            // Remember where we came from only on entry to MEMW.
            if (r_state != ST_MEMW)
                w_prev_next = r_state;
        end else begin
            case (r_state)
                ST_RUN, ST_HAZ: begin
                    if (w_flush_take)
                        w_state_next = ST_FLUSH;
                    else if (w_hazard)
                        w_state_next = ST_HAZ;
                    else
                        w_state_next = ST_RUN;
                end
                ST_FLUSH: w_state_next = ST_RUN;
                ST_MEMW:  w_state_next = r_prev_state;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_hazard_ctrl
//   Table-driven bench for ex_hazard_ctrl. Each table row is one ID-stage
//   cycle with hand-computed expected outputs; a separate hand-written
//   sequence exercises asynchronous reset in the middle of a hazard stall.
//   Expectations follow whichever FORWARD_EN build is compiled.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_hazard_ctrl;
    import ex_hazard_ctrl_pkg::*;

    localparam int REG_W = 3;
    localparam int CNT_W = 3;   // narrow so saturation is reachable

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic             id_rs_use, id_rt_use, id_wr, id_ld;
    logic             ex_take_br, mem_busy;
    logic             stall_if, stall_id, flush_ifid, flush_idex;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles;
    hz_state_e        fsm_state;

    ex_hazard_ctrl #(.REG_W(REG_W), .STALL_CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_id_valid     (id_valid),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_rs_use    (id_rs_use),
        .i_id_rt_use    (id_rt_use),
        .i_id_rd        (id_rd),
        .i_id_wr        (id_wr),
        .i_id_ld        (id_ld),
        .i_ex_take_br   (ex_take_br),
        .i_mem_busy     (mem_busy),
        .o_stall_if     (stall_if),
        .o_stall_id     (stall_id),
        .o_flush_ifid   (flush_ifid),
        .o_flush_idex   (flush_idex),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_stall_cycles (stall_cycles),
        .o_fsm_state    (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [2:0] rs, rt, rd;
        logic       rsu, rtu, wr, ld;
    } ins_t;

    typedef struct {
        ins_t       ins;
        logic       br, busy;
        logic       e_stall, e_flush;
        logic [1:0] e_fa, e_fb;
        hz_state_e  e_st;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic ins_t NOP();
        ins_t r = '{vld:1'b0, rs:3'd0, rt:3'd0, rd:3'd0, rsu:1'b0, rtu:1'b0, wr:1'b0, ld:1'b0};
        return r;
    endfunction
    function automatic ins_t ALU(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        ins_t r = '{vld:1'b1, rs:rs, rt:rt, rd:rd, rsu:1'b1, rtu:1'b1, wr:1'b1, ld:1'b0};
        return r;
    endfunction
    function automatic ins_t ALU1(input logic [2:0] rd, input logic [2:0] rs);
        ins_t r = '{vld:1'b1, rs:rs, rt:3'd0, rd:rd, rsu:1'b1, rtu:1'b0, wr:1'b1, ld:1'b0};
        return r;
    endfunction
    function automatic ins_t LDI(input logic [2:0] rd, input logic [2:0] rs);
        ins_t r = '{vld:1'b1, rs:rs, rt:3'd0, rd:rd, rsu:1'b1, rtu:1'b0, wr:1'b1, ld:1'b1};
        return r;
    endfunction

    task automatic add(input ins_t i, input logic br, input logic busy, input logic st,
                       input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                       input hz_state_e s, input logic [2:0] cnt);
        vec_t v;
        v.ins = i; v.br = br; v.busy = busy; v.e_stall = st; v.e_flush = fl;
        v.e_fa = fa; v.e_fb = fb; v.e_st = s; v.e_cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input ins_t i, input logic br, input logic busy);
        id_valid = i.vld; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_rs_use = i.rsu; id_rt_use = i.rtu; id_wr = i.wr; id_ld = i.ld;
        ex_take_br = br; mem_busy = busy;
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", nm, idx, act, exp);
        end
    endtask

    initial begin
        drive(NOP(), 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_if", -1, stall_if, 0);
        chk("rst_stall_id", -1, stall_id, 0);
        chk("rst_flush",    -1, {flush_ifid, flush_idex}, 0);
        chk("rst_fwd",      -1, {fwd_a, fwd_b}, 0);
        chk("rst_cnt",      -1, stall_cycles, 0);
        chk("rst_state",    -1, fsm_state, ST_RUN);
        @(posedge clk); #1;

`ifdef FORWARD_EN
        // back-to-back ALU: forward from EX/MEM
        add(ALU(1,2,3),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(ALU(2,1,3),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(NOP(),       0,0, 0,0, FWD_EXM,FWD_RF, ST_RUN, 0);
        // one NOP between: forward from MEM/WB
        add(ALU(1,4,5),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(NOP(),       0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(ALU(2,3,1),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(NOP(),       0,0, 0,0, FWD_RF, FWD_MWB,ST_RUN, 0);
        // load-use: one stall, then both operands from MEM/WB
        add(LDI(4,1),    0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(ALU(5,4,4),  0,0, 1,0, FWD_RF, FWD_RF, ST_RUN, 0);
        add(ALU(5,4,4),  0,0, 0,0, FWD_RF, FWD_RF, ST_HAZ, 1);
        add(NOP(),       0,0, 0,0, FWD_MWB,FWD_MWB,ST_RUN, 1);
        // MEM wins over WB when both write r5
        add(ALU(5,6,7),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 1);
        add(ALU(5,6,7),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 1);
        add(ALU(6,5,5),  0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 1);
        add(NOP(),       0,0, 0,0, FWD_EXM,FWD_EXM,ST_RUN, 1);
        // taken branch overrides a pending load-use stall
        add(LDI(7,1),    0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 1);
        add(ALU(1,7,7),  1,0, 0,1, FWD_RF, FWD_RF, ST_RUN, 1);
        add(NOP(),       1,0, 0,0, FWD_RF, FWD_RF, ST_FLUSH,1);
        // mem_busy for 4 cycles over a pending load-use
        add(LDI(2,3),    0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 1);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF, FWD_RF, ST_RUN, 1);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF, FWD_RF, ST_MEMW,1);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF, FWD_RF, ST_MEMW,1);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF, FWD_RF, ST_MEMW,1);
        add(ALU1(3,2),   0,0, 1,0, FWD_RF, FWD_RF, ST_MEMW,1);
        add(ALU1(3,2),   0,0, 0,0, FWD_RF, FWD_RF, ST_RUN, 2);
        add(NOP(),       0,0, 0,0, FWD_MWB,FWD_RF, ST_RUN, 2);
`else
        // RAW without forwarding: 3 stall cycles
        add(ALU(1,2,3),  0,0, 0,0, FWD_RF,FWD_RF, ST_RUN, 0);
        add(ALU(2,1,1),  0,0, 1,0, FWD_RF,FWD_RF, ST_RUN, 0);
        add(ALU(2,1,1),  0,0, 1,0, FWD_RF,FWD_RF, ST_HAZ, 1);
        add(ALU(2,1,1),  0,0, 1,0, FWD_RF,FWD_RF, ST_HAZ, 2);
        add(ALU(2,1,1),  0,0, 0,0, FWD_RF,FWD_RF, ST_HAZ, 3);
        add(NOP(),       0,0, 0,0, FWD_RF,FWD_RF, ST_RUN, 3);
        // mem_busy for 4 cycles over a pending RAW on r2 (producer in MEM)
        add(ALU1(3,2),   0,1, 1,0, FWD_RF,FWD_RF, ST_RUN, 3);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF,FWD_RF, ST_MEMW,3);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF,FWD_RF, ST_MEMW,3);
        add(ALU1(3,2),   0,1, 1,0, FWD_RF,FWD_RF, ST_MEMW,3);
        add(ALU1(3,2),   0,0, 1,0, FWD_RF,FWD_RF, ST_MEMW,3);
        add(ALU1(3,2),   0,0, 1,0, FWD_RF,FWD_RF, ST_RUN, 4);
        add(ALU1(3,2),   0,0, 0,0, FWD_RF,FWD_RF, ST_HAZ, 5);
        // taken branch overrides a pending RAW stall; branch with empty EX is ignored
        add(ALU(5,3,3),  1,0, 0,1, FWD_RF,FWD_RF, ST_RUN, 5);
        add(NOP(),       1,0, 0,0, FWD_RF,FWD_RF, ST_FLUSH,5);
        add(NOP(),       0,0, 0,0, FWD_RF,FWD_RF, ST_RUN, 5);
        // counter saturates at all ones (7 for the 3-bit build)
        add(ALU(6,1,2),  0,0, 0,0, FWD_RF,FWD_RF, ST_RUN, 5);
        add(ALU(7,6,6),  0,0, 1,0, FWD_RF,FWD_RF, ST_RUN, 5);
        add(ALU(7,6,6),  0,0, 1,0, FWD_RF,FWD_RF, ST_HAZ, 6);
        add(ALU(7,6,6),  0,0, 1,0, FWD_RF,FWD_RF, ST_HAZ, 7);
        add(ALU(7,6,6),  0,0, 0,0, FWD_RF,FWD_RF, ST_HAZ, 7);
        add(NOP(),       0,0, 0,0, FWD_RF,FWD_RF, ST_RUN, 7);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ins, tbl[i].br, tbl[i].busy);
            @(negedge clk);
            chk("stall_if",   i, stall_if,     tbl[i].e_stall);
            chk("stall_id",   i, stall_id,     tbl[i].e_stall);
            chk("flush_ifid", i, flush_ifid,   tbl[i].e_flush);
            chk("flush_idex", i, flush_idex,   tbl[i].e_flush);
            chk("fwd_a",      i, fwd_a,        tbl[i].e_fa);
            chk("fwd_b",      i, fwd_b,        tbl[i].e_fb);
            chk("fsm_state",  i, fsm_state,    tbl[i].e_st);
            chk("stall_cnt",  i, stall_cycles, tbl[i].e_cnt);
            $display("step %0d br=%0d busy=%0d stall=%0d flush=%0d fwd=%0d/%0d st=%0d cnt=%0d",
                     i, tbl[i].br, tbl[i].busy, stall_if, flush_ifid, fwd_a, fwd_b,
                     fsm_state, stall_cycles);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a load-use stall
        drive(LDI(1,0), 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(ALU(2,1,1), 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_stall", 100, stall_if, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_stall_if", 101, stall_if, 0);
        chk("async_rst_stall_id", 101, stall_id, 0);
        chk("async_rst_cnt",      101, stall_cycles, 0);
        chk("async_rst_state",    101, fsm_state, ST_RUN);
        chk("async_rst_fwd",      101, {fwd_a, fwd_b}, 0);
        $display("async reset mid-stall: stall=%0d cnt=%0d st=%0d", stall_if, stall_cycles, fsm_state);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_stall", 102, stall_if, 0);
        chk("post_rst_cnt",      102, stall_cycles, 0);
        $display("after reset release: stall=%0d cnt=%0d", stall_if, stall_cycles);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
